// File: rtl/deadlock_mon_pkg.sv
// Shared FSM state type and default sizing constants for the deadlock/stall monitor.
package deadlock_mon_pkg;

  localparam int unsigned N_AXIS_DEF    = 2;
  localparam int unsigned N_INST_DEF    = 14;
  localparam int unsigned N_IDLE_DEF    = 18;
  localparam int unsigned DL_THRESH_DEF = 1024;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } dl_state_e;

endpackage

// File: rtl/deadlock_stall_cond.sv
// Input register stage plus the progress/stall/pattern-change conditions that feed the watchdog FSM.
module deadlock_stall_cond
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned N_AXIS = N_AXIS_DEF,
  parameter int unsigned N_INST = N_INST_DEF,
  parameter int unsigned N_IDLE = N_IDLE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs_i,
  input  logic [N_IDLE-1:0] inst_idle_sigs_i,
  input  logic [N_INST-1:0] inst_block_sigs_i,
  output logic [N_INST-1:0] block_r_o,
  output logic [N_AXIS-1:0] axis_r_o,
  output logic              stall_c_o,
  output logic              sig_changed_c_o
);

  localparam int unsigned SIG_W = N_AXIS + N_INST;

  logic [N_INST-1:0] idle_q;
  logic [N_INST-1:0] block_q;
  logic [N_AXIS-1:0] axis_q;
  logic [SIG_W-1:0]  sig_prev_q;
  logic [SIG_W-1:0]  sig_c;
  logic              progress_c;
  logic              any_active_c;

  // Idle bits above N_INST carry no instance and are deliberately dropped.
  generate
    if (N_IDLE > N_INST) begin : g_idle_spare
      logic unused_idle_c;
      assign unused_idle_c = ^inst_idle_sigs_i[N_IDLE-1:N_INST];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q     <= '0;
      block_q    <= '0;
      axis_q     <= '0;
      sig_prev_q <= '0;
    end else begin
      idle_q     <= inst_idle_sigs_i[N_INST-1:0];
      block_q    <= inst_block_sigs_i;
      axis_q     <= axis_block_sigs_i;
      sig_prev_q <= sig_c;
    end
  end

  always_comb begin
    progress_c   = |(~idle_q & ~block_q);
    any_active_c = |(~idle_q);
    sig_c        = {axis_q, block_q};
  end

  assign stall_c_o       = ~progress_c & (any_active_c | (|axis_q));
  assign sig_changed_c_o = (sig_c != sig_prev_q);
  assign block_r_o       = block_q;
  assign axis_r_o        = axis_q;

endmodule

// File: rtl/deadlock_stall_watchdog.sv
// Dataflow deadlock watchdog: declares deadlock after DL_THRESH cycles of stall with a frozen block pattern.
module deadlock_stall_watchdog
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned N_AXIS    = N_AXIS_DEF,
  parameter int unsigned N_INST    = N_INST_DEF,
  parameter int unsigned N_IDLE    = N_IDLE_DEF,
  parameter int unsigned DL_THRESH = DL_THRESH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_IDLE-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block,
  output logic              deadlock_found,
  output logic [N_INST-1:0] blocked_mask,
  output logic [N_AXIS-1:0] axis_mask,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DL_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_INST-1:0] block_r;
  logic [N_AXIS-1:0] axis_r;
  logic              stall_c;
  logic              sig_changed_c;

  dl_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              block_q, block_d;
  logic              found_q, found_d;
  logic [N_INST-1:0] bmask_q, bmask_d;
  logic [N_AXIS-1:0] amask_q, amask_d;

  deadlock_stall_cond #(
    .N_AXIS (N_AXIS),
    .N_INST (N_INST),
    .N_IDLE (N_IDLE)
  ) u_cond (
    .clock             (clock),
    .reset             (reset),
    .axis_block_sigs_i (axis_block_sigs),
    .inst_idle_sigs_i  (inst_idle_sigs),
    .inst_block_sigs_i (inst_block_sigs),
    .block_r_o         (block_r),
    .axis_r_o          (axis_r),
    .stall_c_o         (stall_c),
    .sig_changed_c_o   (sig_changed_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      block_q <= 1'b0;
      found_q <= 1'b0;
      bmask_q <= '0;
      amask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      found_q <= found_d;
      bmask_q <= bmask_d;
      amask_q <= amask_d;
    end
  end

  // A changing block pattern restarts the count; DEADLOCK holds everything until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    found_d = 1'b0;
    bmask_d = bmask_q;
    amask_d = amask_q;
    unique case (state_q)
      ST_RUN: begin
        if (stall_c) begin
          state_d = ST_SUSPECT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_SUSPECT: begin
        if (!stall_c) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (sig_changed_c) begin
          cnt_d   = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DEADLOCK;
          block_d = 1'b1;
          found_d = 1'b1;
          bmask_d = block_r;
          amask_d = axis_r;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_DEADLOCK: begin
        state_d = ST_DEADLOCK;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign block          = block_q;
  assign deadlock_found = found_q;
  assign blocked_mask   = bmask_q;
  assign axis_mask      = amask_q;
  assign stall_cnt      = cnt_q;

endmodule
